// File: rtl/incr_stream_monitor.sv
// ---------------------------------------------------------------------------
// incr_stream_monitor
//   Consumes the 8-bit incrementing counter stream, one sample per clock.
//   Sums fixed windows of WIN valid samples and pulses each completed sum out.
//   Independently checks that successive valid samples step by +1 (mod 256)
//   and keeps a saturating count of violations.
//
//   Optional feature (macro INCR_STREAM_MON_WRAP_CNT_EN):
//     defined   : __out3 counts valid 0xFF->0x00 steps (mod 256)
//     undefined : __out3 tied to 8'h00
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   __in0  in   8      sample from upstream counter
//   __in1  in   1      sample valid
//   __out0 out  SUM_W  last completed window sum, held until next completion
//   __out1 out  1      one-cycle pulse per completed window
//   __out2 out  ERR_W  saturating sequence-error count
//   __out3 out  8      wrap count (see macro above)
// ---------------------------------------------------------------------------
module incr_stream_monitor #(
  parameter  int unsigned WIN   = 4,
  parameter  int unsigned ERR_W = 8,
  localparam int unsigned SUM_W = 8 + $clog2(WIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       __in0,
  input  logic             __in1,
  output logic [SUM_W-1:0] __out0,
  output logic             __out1,
  output logic [ERR_W-1:0] __out2,
  output logic [7:0]       __out3
);

  localparam int unsigned CNT_W = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum;
  logic             r_pulse;
  logic [7:0]       r_prev;
  logic             r_prev_vld;
  logic [ERR_W-1:0] r_err;

  logic [SUM_W-1:0] w_acc_next;
  logic [SUM_W-1:0] w_sample;
  logic             w_seq_err;

  assign w_sample   = SUM_W'(__in0);
  assign w_acc_next = r_acc + w_sample;
  assign w_seq_err  = r_prev_vld && (__in0 != 8'(r_prev + 8'd1));

  // Window accumulation FSM; only valid cycles advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (__in1) begin
            r_acc   <= w_sample;
            r_cnt   <= CNT_W'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (__in1) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            // This sample completes the window.
            if (r_cnt == CNT_W'(WIN - 1)) begin
              r_sum   <= w_acc_next;
              r_pulse <= 1'b1;
              r_state <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          // A valid sample here opens the next window so none is lost.
          if (__in1) begin
            r_acc   <= w_sample;
            r_cnt   <= CNT_W'(1);
            r_state <= S_ACCUM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sequence checker, independent of the window FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_err      <= '0;
    end else if (__in1) begin
      if (w_seq_err && (r_err != {ERR_W{1'b1}})) begin
        r_err <= r_err + ERR_W'(1);
      end
      r_prev     <= __in0;
      r_prev_vld <= 1'b1;
    end
  end

`ifdef INCR_STREAM_MON_WRAP_CNT_EN
  logic [7:0] r_wrap;

  // Count genuine 0xFF -> 0x00 steps between consecutive valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= '0;
    end else if (__in1 && r_prev_vld && (r_prev == 8'hFF) && (__in0 == 8'h00)) begin
      r_wrap <= r_wrap + 8'd1;
    end
  end

  assign __out3 = r_wrap;
`else
  assign __out3 = 8'h00;
`endif

  assign __out0 = r_sum;
  assign __out1 = r_pulse;
  assign __out2 = r_err;

endmodule

// File: tb/tb_incr_stream_monitor.sv
module tb_incr_stream_monitor;

  localparam int unsigned WIN = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: WIN=4, ERR_W=8
  logic       rst;
  logic       vld;
  logic [7:0] din;
  logic [9:0] sum;
  logic       pulse;
  logic [7:0] err;
  logic [7:0] wrap;

  // Saturation DUT: WIN=4, ERR_W=2
  logic       rst2;
  logic       vld2;
  logic [7:0] din2;
  logic [9:0] sum2;
  logic       pulse2;
  logic [1:0] err2;
  logic [7:0] wrap2;

  incr_stream_monitor #(.WIN(4), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .__in0(din), .__in1(vld),
    .__out0(sum), .__out1(pulse), .__out2(err), .__out3(wrap)
  );

  incr_stream_monitor #(.WIN(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .__in0(din2), .__in1(vld2),
    .__out0(sum2), .__out1(pulse2), .__out2(err2), .__out3(wrap2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: queue of the current window's samples, plain arithmetic.
  int m_q[$];
  int m_sum, m_err, m_wrap, m_prev;
  bit m_pulse, m_pv;

  function automatic void model_reset();
    m_q.delete();
    m_sum = 0; m_err = 0; m_wrap = 0; m_prev = 0;
    m_pulse = 0; m_pv = 0;
  endfunction

  function automatic void model_step(input bit v, input int d);
    m_pulse = 0;
    if (v) begin
      if (m_pv && d != (m_prev + 1) % 256 && m_err < 255) m_err++;
      if (m_pv && m_prev == 255 && d == 0) m_wrap = (m_wrap + 1) % 256;
      m_prev = d;
      m_pv   = 1;
      m_q.push_back(d);
      if (m_q.size() == WIN) begin
        m_sum = 0;
        foreach (m_q[i]) m_sum += m_q[i];
        m_pulse = 1;
        m_q.delete();
      end
    end
  endfunction

  function automatic int exp_wrap();
`ifdef INCR_STREAM_MON_WRAP_CNT_EN
    return m_wrap;
`else
    return 0;
`endif
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_pulse"}, int'(pulse), int'(m_pulse));
    check({tag, "_sum"},   int'(sum),   m_sum);
    check({tag, "_err"},   int'(err),   m_err);
    check({tag, "_wrap"},  int'(wrap),  exp_wrap());
  endtask

  // One clock on the main DUT, model kept in step.
  task automatic cyc(input bit r, input bit v, input int d);
    rst = r; vld = v; din = 8'(d);
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_step(v, d);
  endtask

  typedef struct {
    bit r;
    bit v;
    int d;
    bit p;
    int s;
    int e;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit v, input int d,
                              input bit p, input int s, input int e);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.p = p; t.s = s; t.e = e;
    vecs.push_back(t);
  endfunction

  initial begin
    int seq2[5];
    int exp2[5];
    int nxt;

    rst = 1'b1; vld = 1'b0; din = '0;
    rst2 = 1'b1; vld2 = 1'b0; din2 = '0;

    // ---- saturation instance: 0,2,4,6,8 with ERR_W=2 ----
    seq2 = '{0, 2, 4, 6, 8};
    exp2 = '{0, 1, 2, 3, 3};
    @(posedge clk); #1;
    check("sat_reset_err", int'(err2), 0);
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vld2 = 1'b1; din2 = 8'(seq2[i]);
      @(posedge clk); #1;
      check($sformatf("sat_err%0d", i), int'(err2), exp2[i]);
      if (i == 3) check("sat_sum", int'(sum2), 12);
    end
    vld2 = 1'b0;
    @(posedge clk); #1;
    check("sat_hold", int'(err2), 3);

    // ---- directed table ----
    // 1: 0,1,2,3
    add(1,0,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,1, 0,0,0); add(0,1,2, 0,0,0);
    add(0,1,3, 1,6,0); add(0,0,0, 0,6,0);
    // 2: 0..7 continuous
    add(1,0,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,1, 0,0,0); add(0,1,2, 0,0,0); add(0,1,3, 1,6,0);
    add(0,1,4, 0,6,0); add(0,1,5, 0,6,0); add(0,1,6, 0,6,0); add(0,1,7, 1,22,0);
    add(0,0,0, 0,22,0);
    // 3: gaps between samples
    add(1,0,0, 0,0,0);
    add(0,1,10, 0,0,0); add(0,0,0, 0,0,0); add(0,1,11, 0,0,0); add(0,0,0, 0,0,0);
    add(0,1,12, 0,0,0); add(0,0,0, 0,0,0); add(0,1,13, 1,46,0); add(0,0,0, 0,46,0);
    // 4: sequence break
    add(1,0,0, 0,0,0);
    add(0,1,5, 0,0,0); add(0,1,6, 0,0,0); add(0,1,8, 0,0,1); add(0,1,9, 1,28,1);
    // 5: wrap through 0xFF
    add(1,0,0, 0,0,0);
    add(0,1,254, 0,0,0); add(0,1,255, 0,0,0); add(0,1,0, 0,0,0); add(0,1,1, 1,510,0);
    // 6: reset mid-window
    add(1,0,0, 0,0,0);
    add(0,1,1, 0,0,0); add(0,1,2, 0,0,0); add(1,1,3, 0,0,0);
    add(0,1,3, 0,0,0); add(0,1,4, 0,0,0); add(0,1,5, 0,0,0); add(0,1,6, 1,18,0);
    add(0,0,0, 0,18,0);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d_pulse", i), int'(pulse), int'(vecs[i].p));
      check($sformatf("vec%0d_sum", i),   int'(sum),   vecs[i].s);
      check($sformatf("vec%0d_err", i),   int'(err),   vecs[i].e);
      check($sformatf("vec%0d_wrap", i),  int'(wrap),  exp_wrap());
    end

    // ---- randomized stream against the model ----
    cyc(1, 0, 0);
    check_model("rnd_reset");
    nxt = int'($urandom_range(0, 255));
    for (int n = 0; n < 3000; n++) begin
      bit r, v;
      int d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 255));
      else                           d = nxt;
      if (v) nxt = (d + 1) % 256;
      cyc(r, v, d);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
